// File: rtl/riscv_mstage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mstage_pkg
// Shared definitions for the memory-stage data-memory controller:
//   - controller state encodings (plain constants, usable by legacy tools)
//   - access size encoding used by both storesrc and memext[1:0]
//   - base byte-enable pattern per access size
// -----------------------------------------------------------------------------
package riscv_mstage_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Access size: shared by storesrc and memext[1:0]
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Byte-enable patterns before shifting to the byte offset
    localparam logic [7:0] BE_B = 8'h01;
    localparam logic [7:0] BE_H = 8'h03;
    localparam logic [7:0] BE_W = 8'h0F;
    localparam logic [7:0] BE_D = 8'hFF;

    function automatic logic [7:0] be_base(input size_e sz);
        case (sz)
            SZ_B:    be_base = BE_B;
            SZ_H:    be_base = BE_H;
            SZ_W:    be_base = BE_W;
            default: be_base = BE_D;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mstage_dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// riscv_mstage_dmem_ctrl_if
// Data-cache request/acknowledge bus between the memory-stage controller
// (master) and the dcache (slave).
//   req    master->slave  request, held until ack
//   we     master->slave  1 = write
//   addr   master->slave  doubleword-aligned address
//   wdata  master->slave  lane-replicated store data
//   be     master->slave  byte enables
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  read doubleword, valid with ack
// -----------------------------------------------------------------------------
interface riscv_mstage_dmem_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/riscv_load_extend.sv
// -----------------------------------------------------------------------------
// riscv_load_extend
// Combinational load-data extraction: selects the addressed bytes from a
// doubleword and sign- or zero-extends them to XLEN.
//   i_dword   read doubleword
//   i_off     byte offset within the doubleword
//   i_memext  [1:0] size b/h/w/d, [2] 1 = zero-extend (ignored for d)
//   o_data    extended result
// -----------------------------------------------------------------------------
module riscv_load_extend
    import riscv_mstage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_dword,
    input  logic [2:0]      i_off,
    input  logic [2:0]      i_memext,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] word;
    logic            zext;

    // Bring the addressed byte down to bit 0
    assign word = i_dword >> {i_off, 3'b000};
    assign zext = i_memext[2];

    always_comb begin
        case (size_e'(i_memext[1:0]))
            SZ_B:    o_data = {{(XLEN-8){~zext & word[7]}},   word[7:0]};
            SZ_H:    o_data = {{(XLEN-16){~zext & word[15]}}, word[15:0]};
            SZ_W:    o_data = {{(XLEN-32){~zext & word[31]}}, word[31:0]};
            default: o_data = word;
        endcase
    end
endmodule

// File: rtl/riscv_mstage_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_mstage_dmem_ctrl
// Memory-stage data-memory controller. Launches a dcache access from the E/M
// register contents, holds the pipeline until the dcache acknowledges (or a
// watchdog expires), aligns store data/byte enables and extends load data.
//   i_riscv_mstage_clk / _rst      clock, async active-low reset
//   i_riscv_mstage_globstall       hold DONE while another unit stalls
//   i_riscv_mstage_kill            squash current E/M instruction
//   i_riscv_mstage_dcache_rden/wren, _addr, _store_data, _storesrc,
//   _memext, _misaligned           access description from execute
//   i_riscv_mstage_timer_rden/rdata timer read, same-cycle, no handshake
//   dc                             dcache bus (master side)
//   o_riscv_mstage_stall           to hazard unit
//   o_riscv_mstage_rdata           extended load result
//   o_riscv_mstage_access_fault    watchdog expiry, valid in DONE
// -----------------------------------------------------------------------------
module riscv_mstage_dmem_ctrl
    import riscv_mstage_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic                     i_riscv_mstage_clk,
    input  logic                     i_riscv_mstage_rst,
    input  logic                     i_riscv_mstage_globstall,
    input  logic                     i_riscv_mstage_kill,
    input  logic                     i_riscv_mstage_dcache_rden,
    input  logic                     i_riscv_mstage_dcache_wren,
    input  logic [XLEN-1:0]          i_riscv_mstage_addr,
    input  logic [XLEN-1:0]          i_riscv_mstage_store_data,
    input  logic [1:0]               i_riscv_mstage_storesrc,
    input  logic [2:0]               i_riscv_mstage_memext,
    input  logic                     i_riscv_mstage_misaligned,
    input  logic                     i_riscv_mstage_timer_rden,
    input  logic [XLEN-1:0]          i_riscv_mstage_timer_rdata,
    riscv_mstage_dmem_ctrl_if.master dc,
    output logic                     o_riscv_mstage_stall,
    output logic [XLEN-1:0]          o_riscv_mstage_rdata,
    output logic                     o_riscv_mstage_access_fault
);
    localparam int WD_W = $clog2(MAX_WAIT + 1);

    logic [1:0]      state_q, state_d;
    logic            req_q, req_d;
    logic            fault_q, fault_d;
    logic            killed_q, killed_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            we_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [7:0]      be_q;
    logic [2:0]      off_q, memext_q;

    logic            access, launch;
    logic [7:0]      be_launch;
    logic [XLEN-1:0] wdata_launch, ext_data;

    // Timer reads bypass the dcache entirely, so they block a dcache launch
    assign access = (i_riscv_mstage_dcache_rden | i_riscv_mstage_dcache_wren)
                  & ~i_riscv_mstage_misaligned & ~i_riscv_mstage_kill
                  & ~i_riscv_mstage_timer_rden;
    assign launch = (state_q == ST_IDLE) & access;

    // Store alignment: shifted byte enables, operand replicated per lane size
    always_comb begin
        be_launch = be_base(size_e'(i_riscv_mstage_storesrc)) << i_riscv_mstage_addr[2:0];
        case (size_e'(i_riscv_mstage_storesrc))
            SZ_B:    wdata_launch = {(XLEN/8){i_riscv_mstage_store_data[7:0]}};
            SZ_H:    wdata_launch = {(XLEN/16){i_riscv_mstage_store_data[15:0]}};
            SZ_W:    wdata_launch = {(XLEN/32){i_riscv_mstage_store_data[31:0]}};
            default: wdata_launch = i_riscv_mstage_store_data;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d              = state_q;
        req_d                = req_q;
        fault_d              = fault_q;
        killed_d             = killed_q;
        wd_d                 = wd_q;
        buf_d                = buf_q;
        o_riscv_mstage_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    o_riscv_mstage_stall = 1'b1;
                    state_d  = ST_WAIT;
                    req_d    = 1'b1;
                    fault_d  = 1'b0;
                    killed_d = 1'b0;
                    wd_d     = '0;
                end
            end
            ST_WAIT: begin
                o_riscv_mstage_stall = 1'b1;
                // A kill cannot retract an issued request; just drop the result
                if (i_riscv_mstage_kill) killed_d = 1'b1;
                if (dc.ack) begin
                    buf_d   = dc.rdata;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_q == WD_W'(MAX_WAIT - 1)) begin
                        buf_d   = '0;
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!i_riscv_mstage_globstall) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                    wd_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the asynchronous reset drops req the instant reset asserts; any
    // response still in flight from the dcache is simply never tracked.
    always_ff @(posedge i_riscv_mstage_clk or negedge i_riscv_mstage_rst) begin
        if (!i_riscv_mstage_rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            fault_q  <= 1'b0;
            killed_q <= 1'b0;
            wd_q     <= '0;
            buf_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            memext_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            req_q    <= req_d;
            fault_q  <= fault_d;
            killed_q <= killed_d;
            wd_q     <= wd_d;
            buf_q    <= buf_d;
            // Bus fields are frozen at launch so they stay stable through WAIT
            if (launch) begin
                we_q     <= i_riscv_mstage_dcache_wren;
                be_q     <= be_launch;
                addr_q   <= {i_riscv_mstage_addr[XLEN-1:3], 3'b000};
                wdata_q  <= wdata_launch;
                off_q    <= i_riscv_mstage_addr[2:0];
                memext_q <= i_riscv_mstage_memext;
            end
        end
    end

    riscv_load_extend #(.XLEN(XLEN)) u_load_extend (
        .i_dword  (buf_q),
        .i_off    (off_q),
        .i_memext (memext_q),
        .o_data   (ext_data)
    );

    always_comb begin
        o_riscv_mstage_rdata = '0;
        if (state_q == ST_IDLE && i_riscv_mstage_timer_rden)
            o_riscv_mstage_rdata = i_riscv_mstage_timer_rdata;
        else if (state_q == ST_DONE && !killed_q)
            o_riscv_mstage_rdata = ext_data;
    end

    assign dc.req                      = req_q;
    assign dc.we                       = we_q;
    assign dc.addr                     = addr_q;
    assign dc.wdata                    = wdata_q;
    assign dc.be                       = be_q;
    assign o_riscv_mstage_access_fault = fault_q;
endmodule

// File: tb/tb_riscv_mstage_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_mstage_dmem_ctrl
// Directed, table-driven bench for the memory-stage data-memory controller,
// plus hand-written sequences for timeout, globstall hold, kill, timer and
// asynchronous reset behaviour. MAX_WAIT is set to 4.
// -----------------------------------------------------------------------------
module tb_riscv_mstage_dmem_ctrl;
    localparam int XLEN = 64;

    logic            clk, rst, globstall, kill, rden, wren, misaligned;
    logic            timer_rden;
    logic [XLEN-1:0] addr, sdata, timer_rdata, rdata;
    logic [1:0]      ssrc;
    logic [2:0]      mext;
    logic            stall, fault;

    riscv_mstage_dmem_ctrl_if #(.XLEN(XLEN)) dc_if ();

    riscv_mstage_dmem_ctrl #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
        .i_riscv_mstage_clk          (clk),
        .i_riscv_mstage_rst          (rst),
        .i_riscv_mstage_globstall    (globstall),
        .i_riscv_mstage_kill         (kill),
        .i_riscv_mstage_dcache_rden  (rden),
        .i_riscv_mstage_dcache_wren  (wren),
        .i_riscv_mstage_addr         (addr),
        .i_riscv_mstage_store_data   (sdata),
        .i_riscv_mstage_storesrc     (ssrc),
        .i_riscv_mstage_memext       (mext),
        .i_riscv_mstage_misaligned   (misaligned),
        .i_riscv_mstage_timer_rden   (timer_rden),
        .i_riscv_mstage_timer_rdata  (timer_rdata),
        .dc                          (dc_if.master),
        .o_riscv_mstage_stall        (stall),
        .o_riscv_mstage_rdata        (rdata),
        .o_riscv_mstage_access_fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [63:0] a, sd;
        logic [1:0]  ss;
        logic [2:0]  me;
        logic [63:0] dw;
        int          ack_wait;   // WAIT cycle on which ack arrives, 0 = never
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata, e_rdata;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the most recent run_access
    int          obs_stall, obs_wait;
    logic [63:0] obs_addr, obs_wdata, obs_rdata;
    logic [7:0]  obs_be;
    logic        obs_we, obs_fault, obs_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] a,
                                input logic [63:0] sd, input logic [1:0] ss, input logic [2:0] me,
                                input logic [63:0] dw, input int aw, input logic [63:0] ea,
                                input logic [7:0] eb, input logic [63:0] ew, input logic [63:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.sd = sd; v.ss = ss; v.me = me; v.dw = dw;
        v.ack_wait = aw; v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_rdata = er;
        return v;
    endfunction

    // Drives one access from IDLE and follows it until stall falls (DONE).
    // Returns at a sample point inside DONE with the request inputs released.
    task automatic run_access(input vec_t v, input bit kill_wait);
        bit done = 1'b0;
        @(negedge clk);
        rden = v.rd; wren = v.wr; addr = v.a; sdata = v.sd; ssrc = v.ss; mext = v.me;
        dc_if.ack = 1'b0;
        obs_stall = 0; obs_wait = 0;
        #1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                obs_stall++;
                if (dc_if.req) begin
                    obs_wait++;
                    if (obs_wait == 1) begin
                        obs_addr = dc_if.addr; obs_we = dc_if.we;
                        obs_be = dc_if.be; obs_wdata = dc_if.wdata;
                    end
                    if (kill_wait) kill = 1'b1;
                    if (obs_wait == v.ack_wait) begin
                        dc_if.ack = 1'b1; dc_if.rdata = v.dw;
                    end
                end
                @(negedge clk);
                dc_if.ack = 1'b0;
                #1;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL access_bound: stall still high after 20 cycles");
        end
        obs_rdata = rdata; obs_fault = fault; obs_req = dc_if.req;
        rden = 1'b0; wren = 1'b0; kill = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        vec_t v;
        rst = 1'b0; globstall = 0; kill = 0; rden = 0; wren = 0; misaligned = 0;
        timer_rden = 0; timer_rdata = '0; addr = '0; sdata = '0; ssrc = '0; mext = '0;
        dc_if.ack = 1'b0; dc_if.rdata = '0;

        //            rd wr addr       store data             ss     me      dcache dword           aw  exp addr   be     exp wdata               exp rdata
        vecs[0]  = mk(1, 0, 64'h1000, 64'h0,                 2'b11, 3'b011, 64'h8877665544332211, 3, 64'h1000, 8'h00, 64'h0,                 64'h8877665544332211);
        vecs[1]  = mk(1, 0, 64'h1003, 64'h0,                 2'b11, 3'b000, 64'h0000000080000000, 1, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFF80);
        vecs[2]  = mk(1, 0, 64'h1003, 64'h0,                 2'b11, 3'b100, 64'h0000000080000000, 1, 64'h1000, 8'h00, 64'h0,                 64'h0000000000000080);
        vecs[3]  = mk(1, 0, 64'h1000, 64'h0,                 2'b11, 3'b000, 64'h123456789ABCDE7F, 1, 64'h1000, 8'h00, 64'h0,                 64'h000000000000007F);
        vecs[4]  = mk(1, 0, 64'h1002, 64'h0,                 2'b11, 3'b001, 64'h0000000080010000, 2, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFF8001);
        vecs[5]  = mk(1, 0, 64'h1002, 64'h0,                 2'b11, 3'b101, 64'h0000000080010000, 1, 64'h1000, 8'h00, 64'h0,                 64'h0000000000008001);
        vecs[6]  = mk(1, 0, 64'h1004, 64'h0,                 2'b11, 3'b010, 64'h89ABCDEF00000000, 1, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFF89ABCDEF);
        vecs[7]  = mk(1, 0, 64'h1004, 64'h0,                 2'b11, 3'b110, 64'h89ABCDEF00000000, 1, 64'h1000, 8'h00, 64'h0,                 64'h0000000089ABCDEF);
        vecs[8]  = mk(1, 0, 64'h2008, 64'h0,                 2'b11, 3'b111, 64'hF0000000000000A1, 1, 64'h2008, 8'h00, 64'h0,                 64'hF0000000000000A1);
        vecs[9]  = mk(1, 0, 64'h1007, 64'h0,                 2'b11, 3'b000, 64'hFE00000000000000, 1, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFFFE);
        vecs[10] = mk(0, 1, 64'h1006, 64'hFFFF00001234BEEF, 2'b01, 3'b011, 64'h0,                 1, 64'h1000, 8'hC0, 64'hBEEFBEEFBEEFBEEF, 64'h0);
        vecs[11] = mk(0, 1, 64'h1007, 64'h00000000000077A5, 2'b00, 3'b011, 64'h0,                 1, 64'h1000, 8'h80, 64'hA5A5A5A5A5A5A5A5, 64'h0);
        vecs[12] = mk(0, 1, 64'h2004, 64'hCAFE0000DEADBEEF, 2'b10, 3'b011, 64'h0,                 2, 64'h2000, 8'hF0, 64'hDEADBEEFDEADBEEF, 64'h0);
        vecs[13] = mk(0, 1, 64'h3008, 64'h0123456789ABCDEF, 2'b11, 3'b011, 64'h0,                 1, 64'h3008, 8'hFF, 64'h0123456789ABCDEF, 64'h0);

        // Reset state
        #12;
        check("rst req",   64'(dc_if.req), 64'h0);
        check("rst we",    64'(dc_if.we),  64'h0);
        check("rst be",    64'(dc_if.be),  64'h0);
        check("rst stall", 64'(stall),     64'h0);
        check("rst fault", 64'(fault),     64'h0);
        check("rst rdata", rdata,          64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven accesses
        for (int i = 0; i < 14; i++) begin
            run_access(vecs[i], 1'b0);
            check($sformatf("v%0d stall", i), 64'(obs_stall), 64'(vecs[i].ack_wait + 1));
            check($sformatf("v%0d addr", i),  obs_addr,       vecs[i].e_addr);
            check($sformatf("v%0d we", i),    64'(obs_we),    64'(vecs[i].wr));
            if (vecs[i].wr) begin
                check($sformatf("v%0d be", i),    64'(obs_be), 64'(vecs[i].e_be));
                check($sformatf("v%0d wdata", i), obs_wdata,   vecs[i].e_wdata);
            end
            check($sformatf("v%0d rdata", i), obs_rdata,      vecs[i].e_rdata);
            check($sformatf("v%0d fault", i), 64'(obs_fault), 64'h0);
            check($sformatf("v%0d req_done", i), 64'(obs_req), 64'h0);
        end

        // Watchdog: no ack, req held 4 WAIT cycles then fault; hold DONE 3 cycles
        v = mk(1, 0, 64'h4000, 64'h0, 2'b11, 3'b011, 64'h0, 0, 64'h4000, 8'h00, 64'h0, 64'h0);
        run_access(v, 1'b0);
        check("wd wait cycles", 64'(obs_wait),  64'd4);
        check("wd stall",       64'(obs_stall), 64'd5);
        check("wd fault",       64'(obs_fault), 64'h1);
        check("wd req drop",    64'(obs_req),   64'h0);
        globstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("wd hold%0d fault", i), 64'(fault),     64'h1);
            check($sformatf("wd hold%0d stall", i), 64'(stall),     64'h0);
        end
        globstall = 1'b0;
        @(negedge clk); #1;
        check("wd clear fault", 64'(fault), 64'h0);

        // Globstall in DONE keeps the load result and issues no new request
        run_access(vecs[0], 1'b0);
        check("gs rdata", obs_rdata, 64'h8877665544332211);
        globstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("gs hold%0d rdata", i), rdata,           64'h8877665544332211);
            check($sformatf("gs hold%0d req", i),   64'(dc_if.req),  64'h0);
            check($sformatf("gs hold%0d stall", i), 64'(stall),      64'h0);
        end
        globstall = 1'b0;
        @(negedge clk); #1;
        check("gs release rdata", rdata, 64'h0);

        // Kill during WAIT: access completes, result discarded
        run_access(vecs[0], 1'b1);
        check("killwait stall", 64'(obs_stall), 64'd4);
        check("killwait rdata", obs_rdata,      64'h0);

        // Kill or misaligned in IDLE: no stall, no request
        @(negedge clk);
        rden = 1'b1; addr = 64'h1000; kill = 1'b1;
        #1 check("kill idle stall", 64'(stall), 64'h0);
        @(negedge clk); #1;
        check("kill idle req", 64'(dc_if.req), 64'h0);
        kill = 1'b0; rden = 1'b0; wren = 1'b1; misaligned = 1'b1;
        #1 check("misal stall", 64'(stall), 64'h0);
        @(negedge clk); #1;
        check("misal req", 64'(dc_if.req), 64'h0);
        wren = 1'b0; misaligned = 1'b0;

        // Timer read wins over a simultaneous dcache read
        @(negedge clk);
        timer_rden = 1'b1; rden = 1'b1; timer_rdata = 64'h00000123DEADBEEF;
        #1;
        check("timer rdata", rdata,       64'h00000123DEADBEEF);
        check("timer stall", 64'(stall),  64'h0);
        @(negedge clk); #1;
        check("timer req",   64'(dc_if.req), 64'h0);
        timer_rden = 1'b0; rden = 1'b0;

        // Ack outside WAIT is ignored
        @(negedge clk);
        dc_if.ack = 1'b1; dc_if.rdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        dc_if.ack = 1'b0;
        #1;
        check("stray ack stall", 64'(stall), 64'h0);
        check("stray ack rdata", rdata,      64'h0);

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        rden = 1'b1; addr = 64'h1000; mext = 3'b011;
        @(negedge clk); #1;
        check("rstwait req before", 64'(dc_if.req), 64'h1);
        rst = 1'b0; rden = 1'b0;
        #1;
        check("rstwait req",   64'(dc_if.req), 64'h0);
        check("rstwait stall", 64'(stall),     64'h0);
        @(negedge clk);
        rst = 1'b1;
        run_access(vecs[1], 1'b0);
        check("post rst stall", 64'(obs_stall), 64'd2);
        check("post rst rdata", obs_rdata,      64'hFFFFFFFFFFFFFF80);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
